// File: rtl/window_feeder.sv
// Raster-to-5x5 window generator: four line buffers plus a 5x5 shift register,
// with a single valid/ready output stage in front of the consumer.
module window_feeder #(
    parameter int bitwidth   = 32,
    parameter int map_width  = 32,
    parameter int map_height = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [bitwidth-1:0] in_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [bitwidth-1:0] window [4:0][4:0],
    output logic                       frame_last
);

    localparam int CW = (map_width  > 1) ? $clog2(map_width)  : 1;
    localparam int RW = (map_height > 1) ? $clog2(map_height) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          beat, qual, col_end, row_end;

    logic signed [bitwidth-1:0] win_q  [4:0][4:0];
    logic signed [bitwidth-1:0] lb_q   [3:0][map_width];
    logic signed [bitwidth-1:0] column [4:0];

    assign in_ready = !valid_q || out_ready;
    assign beat     = in_valid && in_ready;
    assign col_end  = (col_q == CW'(map_width - 1));
    assign row_end  = (row_q == RW'(map_height - 1));
    assign qual     = beat && (row_q >= RW'(4)) && (col_q >= CW'(4));

    // lb_q[0] holds the previous row, lb_q[3] the row four above the current one
    always_comb begin
        column[0] = lb_q[3][col_q];
        column[1] = lb_q[2][col_q];
        column[2] = lb_q[1][col_q];
        column[3] = lb_q[0][col_q];
        column[4] = in_pixel;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (beat) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        if (qual) begin
            valid_d = 1'b1;
            last_d  = row_end && col_end;
        end else if (out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            // Beats only happen when the held window is free, so shifting here never disturbs it
            if (beat) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        win_q[i][j] <= win_q[i][j+1];
                    end
                    win_q[i][4] <= column[i];
                end
            end
        end
    end

    // Stale contents are harmless: windows only start once rows 0..3 of the frame are written
    always_ff @(posedge clk) begin
        if (beat) begin
            lb_q[0][col_q] <= in_pixel;
            lb_q[1][col_q] <= lb_q[0][col_q];
            lb_q[2][col_q] <= lb_q[1][col_q];
            lb_q[3][col_q] <= lb_q[2][col_q];
        end
    end

    assign window     = win_q;
    assign out_valid  = valid_q;
    assign frame_last = last_q;

endmodule
